// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
//
// Purpose:
//   Clock-gate controller for a group of requesters. When any requester
//   raises its request, the controller opens the downstream clock gate. It
//   waits a fixed number of wake cycles for the gated clock to settle. It
//   then acknowledges each active requester individually. When every request
//   has dropped, the gate stays open for a programmable idle window before it
//   closes. A request that arrives during that window reopens the grant
//   immediately, without another wake sequence.
//
// Parameters:
//   NREQ        - number of requesters (1..8)
//   WAKE_CYCLES - cycles spent in WAKE before granting (1..15)
//   IDLE_CYCLES - idle cycles tolerated before gating off (1..255)
//
// Ports:
//   clk_in     in   1     free-running source clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   req        in   NREQ  per-requester level request (four-phase with ack)
//   ack        out  NREQ  per-requester grant, registered
//   gate_en    out  1     clock buffer enable, straight from a flop
//   state      out  2     FSM state: OFF=0, WAKE=1, ON=2, IDLE_WAIT=3
//   wake_count out  16    saturating count of OFF->WAKE transitions
//                         (present only when CLK_GATE_CTRL_STATS_EN is defined)
//
// Build option:
//   CLK_GATE_CTRL_STATS_EN - when defined, adds the wake_count output and its
//                            counter. All other behaviour is unchanged.
// ---------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int NREQ        = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic            gate_en,
  output logic [1:0]      state
`ifdef CLK_GATE_CTRL_STATS_EN
  ,
  output logic [15:0]     wake_count
`endif
);

  // Each counter only ever holds its load value (parameter - 1) and counts
  // down from there, so it is sized for that maximum.
  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int ICW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [WCW-1:0] WAKE_LOAD = WCW'(WAKE_CYCLES - 1);
  localparam logic [ICW-1:0] IDLE_LOAD = ICW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAKE      = 2'd1,
    ON        = 2'd2,
    IDLE_WAIT = 2'd3
  } state_e;

  state_e          state_q,   state_d;
  logic [WCW-1:0]  wakeCnt_q, wakeCnt_d;
  logic [ICW-1:0]  idleCnt_q, idleCnt_d;
  logic            gateEn_q,  gateEn_d;
  logic [NREQ-1:0] ack_q,     ack_d;
  logic            anyReq;

  assign anyReq = |req;

  // Next-state logic. The gate enable changes only on transitions into or
  // out of OFF. A request in IDLE_WAIT beats idle expiry, including when the
  // idle counter has already reached zero. Acks follow the requests only
  // while the controller is in ON. That gives the one-cycle grant latency
  // after ON is entered, and it keeps ack low whenever the gate is closed.
  always_comb begin
    state_d   = state_q;
    wakeCnt_d = wakeCnt_q;
    idleCnt_d = idleCnt_q;
    gateEn_d  = gateEn_q;
    ack_d     = '0;
    unique case (state_q)
      OFF: begin
        gateEn_d = 1'b0;
        if (anyReq) begin
          state_d   = WAKE;
          gateEn_d  = 1'b1;
          wakeCnt_d = WAKE_LOAD;
        end
      end
      WAKE: begin
        // Once started, the wake sequence always runs to completion. It
        // cannot be aborted because the clock buffer is already enabled.
        if (wakeCnt_q == '0) begin
          state_d = ON;
        end else begin
          wakeCnt_d = wakeCnt_q - 1'b1;
        end
      end
      ON: begin
        ack_d = req;
        if (!anyReq) begin
          state_d   = IDLE_WAIT;
          idleCnt_d = IDLE_LOAD;
        end
      end
      IDLE_WAIT: begin
        if (anyReq) begin
          state_d = ON;
        end else if (idleCnt_q == '0) begin
          state_d  = OFF;
          gateEn_d = 1'b0;
        end else begin
          idleCnt_d = idleCnt_q - 1'b1;
        end
      end
      default: begin
        state_d  = OFF;
        gateEn_d = 1'b0;
      end
    endcase
  end

  // A single state register holds the FSM state, the counters and the
  // registered outputs. Reset is asynchronous, so it closes the gate and
  // drops every grant at once, even in the middle of a wake or grant phase.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      wakeCnt_q <= '0;
      idleCnt_q <= '0;
      gateEn_q  <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      wakeCnt_q <= wakeCnt_d;
      idleCnt_q <= idleCnt_d;
      gateEn_q  <= gateEn_d;
      ack_q     <= ack_d;
    end
  end

  assign state   = state_q;
  assign gate_en = gateEn_q;
  assign ack     = ack_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0] wakeCount_q;

  // Counts wake-ups out of OFF and holds at all-ones rather than wrapping.
  // Returning from IDLE_WAIT to ON is not a wake-up, so it is not counted.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wakeCount_q <= '0;
    end else if ((state_q == OFF) && (state_d == WAKE) &&
                 (wakeCount_q != 16'hFFFF)) begin
      wakeCount_q <= wakeCount_q + 16'd1;
    end
  end

  assign wake_count = wakeCount_q;
`endif

endmodule
